// File: rtl/fpu_issue_ctrl.sv
// Issue/collect controller for the 3-stage FP subtract unit (c = a - b), with credit-based in-order response FIFO.
// Optional macro FPU_ISSUE_BYPASS_EN forwards a collected result straight to the response port when the FIFO is empty.
module fpu_issue_ctrl #(
  parameter int LAT   = 3,
  parameter int DEPTH = 4,
  parameter int TAGW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     fpu_a,
  output logic [31:0]     fpu_b,
  output logic            fpu_en,
  input  logic [31:0]     fpu_c,
  input  logic            fpu_ready,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_data,
  output logic [TAGW-1:0] rsp_tag,
  output logic            err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(LAT + 2);
  localparam int EW = 32 + TAGW;

  logic [31:0]                fpu_a_q, fpu_a_d;
  logic [31:0]                fpu_b_q, fpu_b_d;
  logic                       fpu_en_q, fpu_en_d;
  logic [LAT:0]               vpipe_q, vpipe_d;
  logic [LAT:0][TAGW-1:0]     tpipe_q, tpipe_d;
  logic [CW-1:0]              inflight_q, inflight_d;
  logic [CW-1:0]              wptr_q, wptr_d;
  logic [CW-1:0]              rptr_q, rptr_d;
  logic [DEPTH-1:0][EW-1:0]   mem_q, mem_d;
  logic                       err_q, err_d;
  logic [DW-1:0]              drain_q, drain_d;

  logic [CW-1:0] count_s;
  logic [EW-1:0] head_s;
  logic          empty_s, accept_s, collect_s, wr_s, pop_s, grace_s;

  // Credit admission, delay line, FIFO bookkeeping and error detection
  always_comb begin
    count_s   = wptr_q - rptr_q;
    empty_s   = (wptr_q == rptr_q);
    head_s    = mem_q[rptr_q[AW-1:0]];
    req_ready = (({1'b0, inflight_q} + {1'b0, count_s}) < (CW + 1)'(DEPTH));
    accept_s  = req_valid & req_ready;
    collect_s = fpu_ready & vpipe_q[LAT];
    grace_s   = (drain_q != {DW{1'b0}});
    pop_s     = ~empty_s & rsp_ready;
`ifdef FPU_ISSUE_BYPASS_EN
    // An empty FIFO lets the collected result be presented in the same cycle
    rsp_valid = ~empty_s | collect_s;
    rsp_data  = empty_s ? fpu_c : head_s[EW-1:TAGW];
    rsp_tag   = empty_s ? tpipe_q[LAT] : head_s[TAGW-1:0];
    wr_s      = collect_s & ~(empty_s & rsp_ready);
`else
    rsp_valid = ~empty_s;
    rsp_data  = head_s[EW-1:TAGW];
    rsp_tag   = head_s[TAGW-1:0];
    wr_s      = collect_s;
`endif

    fpu_en_d = accept_s;
    if (accept_s) begin
      fpu_a_d = req_a;
      fpu_b_d = {req_b[31] ^ ~req_op, req_b[30:0]};
    end else begin
      fpu_a_d = fpu_a_q;
      fpu_b_d = fpu_b_q;
    end

    vpipe_d    = {vpipe_q[LAT-1:0], accept_s};
    tpipe_d[0] = accept_s ? req_tag : {TAGW{1'b0}};
    for (int i = 1; i <= LAT; i++) begin
      tpipe_d[i] = tpipe_q[i-1];
    end

    case ({accept_s, collect_s})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    mem_d = mem_q;
    if (wr_s) begin
      mem_d[wptr_q[AW-1:0]] = {fpu_c, tpipe_q[LAT]};
      wptr_d = wptr_q + CW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    rptr_d = pop_s ? rptr_q + CW'(1) : rptr_q;

    drain_d = grace_s ? drain_q - DW'(1) : drain_q;
    // Stale strobes from the unreset unit may drain right after reset
    err_d = err_q | ((fpu_ready ^ vpipe_q[LAT]) & ~(fpu_ready & ~vpipe_q[LAT] & grace_s));
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_a_q    <= 32'h0;
      fpu_b_q    <= 32'h0;
      fpu_en_q   <= 1'b0;
      vpipe_q    <= '0;
      tpipe_q    <= '0;
      inflight_q <= {CW{1'b0}};
      wptr_q     <= {CW{1'b0}};
      rptr_q     <= {CW{1'b0}};
      mem_q      <= '0;
      err_q      <= 1'b0;
      drain_q    <= DW'(LAT + 1);
    end else begin
      fpu_a_q    <= fpu_a_d;
      fpu_b_q    <= fpu_b_d;
      fpu_en_q   <= fpu_en_d;
      vpipe_q    <= vpipe_d;
      tpipe_q    <= tpipe_d;
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      mem_q      <= mem_d;
      err_q      <= err_d;
      drain_q    <= drain_d;
    end
  end

  assign fpu_a  = fpu_a_q;
  assign fpu_b  = fpu_b_q;
  assign fpu_en = fpu_en_q;
  assign err    = err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: behavioural 3-stage subtract unit plus an in-order response scoreboard.
module tb_fpu_issue_ctrl;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int TAGW  = 5;
`ifdef FPU_ISSUE_BYPASS_EN
  localparam int RSP_LAT = LAT + 1;
`else
  localparam int RSP_LAT = LAT + 2;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0, req_ready, req_op = 1'b0;
  logic [31:0]     req_a = 32'h0, req_b = 32'h0;
  logic [TAGW-1:0] req_tag = '0;
  logic [31:0]     fpu_a, fpu_b, fpu_c;
  logic            fpu_en, fpu_ready;
  logic            rsp_valid, rsp_ready = 1'b0;
  logic [31:0]     rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic            err;

  fpu_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_en(fpu_en),
    .fpu_c(fpu_c), .fpu_ready(fpu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .err(err)
  );

  always #5 clk = ~clk;

  function automatic real sp2real(input logic [31:0] s);
    logic [10:0] e;
    if (s[30:0] == 31'h0) return 0.0;
    e = {3'b000, s[30:23]} + 11'd896;
    return $bitstoreal({s[31], e, s[22:0], 29'h0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural unit: no reset, fixed LAT-edge latency, c = a - b
  logic [2:0]  en_p = 3'b000;
  logic [31:0] c_p [3] = '{default: 32'h0};
  logic        spur = 1'b0;
  always @(posedge clk) begin
    en_p   <= {en_p[1:0], fpu_en};
    c_p[0] <= real2sp(sp2real(fpu_a) - sp2real(fpu_b));
    c_p[1] <= c_p[0];
    c_p[2] <= c_p[1];
  end
  assign fpu_ready = en_p[2] | spur;
  assign fpu_c     = c_p[2];

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [31:0]     data;
    logic [31:0]     cyc;
  } sb_t;

  sb_t         sb[$];
  int          checks = 0, failures = 0;
  int          cyc_n = 0, n_acc = 0, n_rsp = 0, n_vld = 0;
  logic [31:0] exp_next = 32'h0;
  logic        chk_lat = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    sb_t e;
    if (req_valid && req_ready) begin
      sb.push_back('{tag: req_tag, data: exp_next, cyc: cyc_n});
      n_acc++;
    end
    if (rsp_valid) n_vld++;
    if (rsp_valid && rsp_ready) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_tag", {{(32-TAGW){1'b0}}, rsp_tag}, {{(32-TAGW){1'b0}}, e.tag});
        chk("rsp_data", rsp_data, e.data);
        if (chk_lat) chk("rsp_latency", cyc_n - e.cyc, RSP_LAT);
      end
    end
  endtask

  task automatic cyc();
    #1;
    observe();
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 40;
    while (sb.size() != 0 && budget > 0) begin
      cyc();
      budget--;
    end
    chk(tag, sb.size(), 32'd0);
  endtask

  initial begin
    int base, cnt, vcnt, k;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_fpu_en", {31'b0, fpu_en}, 32'd0);
    chk("rst_fpu_a", fpu_a, 32'h0);
    chk("rst_fpu_b", fpu_b, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_tag", {{(32-TAGW){1'b0}}, rsp_tag}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    rst = 1'b0;
    repeat (6) cyc();

    // Single fsub 3.0 - 1.0
    rsp_ready = 1'b1; chk_lat = 1'b1;
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'h40400000; req_b = 32'h3F800000;
    req_tag = 5'd7; exp_next = 32'h40000000;
    cnt = n_rsp; vcnt = n_vld;
    cyc();
    req_valid = 1'b0;
    chk("fsub_fpu_en", {31'b0, fpu_en}, 32'd1);
    chk("fsub_fpu_a", fpu_a, 32'h40400000);
    chk("fsub_fpu_b", fpu_b, 32'h3F800000);
    repeat (8) cyc();
    chk("fsub_rsp_count", n_rsp - cnt, 32'd1);
    chk("fsub_valid_cycles", n_vld - vcnt, 32'd1);

    // Single fadd 1.0 + 1.0
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'h3F800000; req_b = 32'h3F800000;
    req_tag = 5'd9; exp_next = 32'h40000000;
    cnt = n_rsp;
    cyc();
    req_valid = 1'b0;
    chk("fadd_fpu_b", fpu_b, 32'hBF800000);
    repeat (8) cyc();
    chk("fadd_rsp_count", n_rsp - cnt, 32'd1);

    // Back-pressure: six offered, four credits
    chk_lat = 1'b0; rsp_ready = 1'b0;
    base = n_acc;
    for (int i = 0; i < 6; i++) begin
      k = n_acc - base;
      req_valid = 1'b1; req_op = 1'b1; req_tag = TAGW'(k);
      req_a = real2sp(10.0 + real'(k)); req_b = real2sp(2.0);
      exp_next = real2sp(8.0 + real'(k));
      cyc();
      if (i == 3) chk("bp_four_consecutive", n_acc - base, 32'd4);
    end
    req_valid = 1'b0;
    chk("bp_accepted", n_acc - base, 32'd4);
    chk("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
    repeat (6) cyc();
    chk("bp_still_blocked", {31'b0, req_ready}, 32'd0);
    chk("bp_head_tag", {{(32-TAGW){1'b0}}, rsp_tag}, 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("bp_ready_before_pop", {31'b0, req_ready}, 32'd0);
    cyc();
    chk("bp_ready_after_pop", {31'b0, req_ready}, 32'd1);
    drain("bp_drain");

    // Streaming 20 requests with rsp_ready held high
    chk_lat = 1'b1;
    base = n_acc; cnt = n_rsp;
    for (int budget = 200; budget > 0 && (n_acc - base) < 20; budget--) begin
      k = n_acc - base;
      req_valid = 1'b1; req_op = k[0]; req_tag = TAGW'(k + 3);
      req_a = real2sp(real'(k + 3)); req_b = real2sp(real'(k % 4 + 1));
      exp_next = k[0] ? real2sp(real'(k + 3) - real'(k % 4 + 1))
                      : real2sp(real'(k + 3) + real'(k % 4 + 1));
      cyc();
    end
    req_valid = 1'b0;
    chk("stream_accepted", n_acc - base, 32'd20);
    drain("stream_drain");
    chk("stream_rsp_count", n_rsp - cnt, 32'd20);
    chk("stream_err", {31'b0, err}, 32'd0);

    // Reset while two operations are in flight
    chk_lat = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1; req_op = 1'b1; req_tag = TAGW'(20 + i);
      req_a = real2sp(5.0); req_b = real2sp(1.0); exp_next = real2sp(4.0);
      cyc();
    end
    req_valid = 1'b0;
    cyc();
    rst = 1'b1;
    sb.delete();
    vcnt = n_vld;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    chk("midrst_no_rsp", n_vld - vcnt, 32'd0);
    chk("midrst_err", {31'b0, err}, 32'd0);
    chk("midrst_req_ready", {31'b0, req_ready}, 32'd1);

    // Spurious fpu_ready well after reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (10) cyc();
    chk("proto_err_before", {31'b0, err}, 32'd0);
    spur = 1'b1;
    cyc();
    spur = 1'b0;
    chk("proto_err_set", {31'b0, err}, 32'd1);
    repeat (5) cyc();
    chk("proto_err_sticky", {31'b0, err}, 32'd1);
    rst = 1'b1;
    #1;
    chk("proto_err_cleared", {31'b0, err}, 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
